// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops with a persistent flags register,
// plus an iterative shift-add unsigned multiplier behind a start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       flags,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_CMP = 4'h6;
  localparam logic [3:0] OP_ADC = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [WIDTH-1:0]       result_hi_q, result_hi_d;
  logic [7:0]             flags_q, flags_d;
  logic                   done_q, done_d;
  logic                   illegal_q, illegal_d;

  logic [WIDTH:0]         add_sum, adc_sum, sub_diff, step_sum;
  logic [2*WIDTH-1:0]     prod_step;
  logic [WIDTH-1:0]       res;
  logic                   wr, c_f, v_f;

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign adc_sum  = add_sum + {{WIDTH{1'b0}}, flags_q[3]};
  assign sub_diff = {1'b0, a} - {1'b0, b};

  // prod_q holds {accumulator, remaining multiplier bits}; each step adds then shifts right
  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {step_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    res         = '0;
    wr          = 1'b0;
    c_f         = 1'b0;
    v_f         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_ADD: begin
              wr  = 1'b1;
              res = add_sum[WIDTH-1:0];
              c_f = add_sum[WIDTH];
              v_f = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADC: begin
              wr  = 1'b1;
              res = adc_sum[WIDTH-1:0];
              c_f = adc_sum[WIDTH];
              v_f = (a[WIDTH-1] == b[WIDTH-1]) && (adc_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              wr  = 1'b1;
              res = sub_diff[WIDTH-1:0];
              c_f = sub_diff[WIDTH];
              v_f = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: begin wr = 1'b1; res = a & b; end
            OP_OR:  begin wr = 1'b1; res = a | b; end
            OP_XOR: begin wr = 1'b1; res = a ^ b; end
            OP_NOT: begin wr = 1'b1; res = ~a; end
            OP_SHL: begin wr = 1'b1; res = {a[WIDTH-2:0], 1'b0}; c_f = a[WIDTH-1]; end
            OP_SHR: begin wr = 1'b1; res = {1'b0, a[WIDTH-1:1]}; c_f = a[0]; end
            OP_CMP: begin
              flags_d[0] = (a == b);
              flags_d[1] = (a > b);
              done_d     = 1'b1;
            end
            OP_MUL: begin
              state_d = S_MUL;
              cnt_d   = CNT_W'(WIDTH);
              mcand_d = a;
              prod_d  = {{WIDTH{1'b0}}, b};
            end
            default: begin
              done_d    = 1'b1;
              illegal_d = 1'b1;
            end
          endcase
          if (wr) begin
            result_d    = res;
            result_hi_d = '0;
            flags_d     = {2'b00, v_f, res[WIDTH-1], c_f, (res == '0), flags_q[1:0]};
            done_d      = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_IDLE;
          result_d    = prod_step[WIDTH-1:0];
          result_hi_d = prod_step[2*WIDTH-1:WIDTH];
          flags_d     = {2'b00, 1'b0, 1'b0, (prod_step[2*WIDTH-1:WIDTH] != '0),
                         (prod_step == '0), flags_q[1:0]};
          done_d      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign busy      = (state_q == S_MUL);
  assign done      = done_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a behavioural model pushes the expected outcome of each
// accepted op; each test pops and compares when done is observed.
module tb_seq_alu;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] op = '0;
  logic [7:0] a = '0, b = '0;
  logic [7:0] result, result_hi, flags;
  logic       busy, done, illegal;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic [7:0] flg;
    logic       ill;
  } exp_t;

  exp_t       sb[$];
  exp_t       e, got;
  logic [7:0] m_res = '0, m_hi = '0, m_flg = '0;
  int         n_vec = 0, n_err = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .result(result), .result_hi(result_hi), .flags(flags),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign got = '{res: result, hi: result_hi, flg: flags, ill: illegal};

  // Independent integer-arithmetic reference model of the architectural state
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int ua = int'(x), ub = int'(y);
    int sa = int'($signed(x)), sy = int'($signed(y));
    int s = 0, sv = 0, p;
    logic w = 1'b1, c = 1'b0, il = 1'b0;
    exp_t r;
    case (o)
      4'h0: begin s = ua + ub; sv = sa + sy; c = (s > 255); end
      4'h1: begin s = ua - ub; sv = sa - sy; c = (ua < ub); end
      4'h2: s = ua & ub;
      4'h3: s = ua | ub;
      4'h4: s = ua ^ ub;
      4'h5: s = 255 - ua;
      4'h7: begin
        s = ua + ub + int'(m_flg[3]); sv = sa + sy + int'(m_flg[3]); c = (s > 255);
      end
      4'h8: begin s = ua * 2; c = x[7]; end
      4'h9: begin s = ua / 2; c = x[0]; end
      4'h6: begin w = 1'b0; m_flg[0] = (ua == ub); m_flg[1] = (ua > ub); end
      4'hA: begin
        w = 1'b0; p = ua * ub;
        m_res = 8'(p % 256); m_hi = 8'(p / 256);
        m_flg[2] = (p == 0); m_flg[3] = (m_hi != 0); m_flg[4] = 1'b0; m_flg[5] = 1'b0;
      end
      default: begin w = 1'b0; il = 1'b1; end
    endcase
    if (w) begin
      m_res = 8'(s & 255);
      m_hi  = 8'h00;
      m_flg[2] = (m_res == 8'h00);
      m_flg[3] = c;
      m_flg[4] = m_res[7];
      m_flg[5] = (sv > 127) || (sv < -128);
    end
    r = '{res: m_res, hi: m_hi, flg: m_flg, ill: il};
    return r;
  endfunction

  // Drive one start pulse, push the expected outcome; returns at accept edge + #1
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({result, result_hi, flags, busy, done, illegal} !== 27'd0) begin
      n_err++; $display("FAIL reset_state: got %h, want 0", {result, result_hi, flags, busy, done, illegal});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_adc;
    issue(4'h0, 8'hFF, 8'h01);
    e = sb.pop_front();
    n_vec++;
    if (!done || got !== e || e.res !== 8'h00 || e.flg[3:2] !== 2'b11) begin
      n_err++; $display("FAIL add: done=%b got %h want %h", done, got, e);
    end
    issue(4'h7, 8'h00, 8'h00);
    e = sb.pop_front();
    n_vec++;
    if (!done || got !== e || e.res !== 8'h01) begin
      n_err++; $display("FAIL adc_b2b: done=%b got %h want %h", done, got, e);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL adc_done_width: done=%b want 0", done); end
  endtask

  task automatic test_sub_cmp;
    issue(4'h1, 8'h80, 8'h01);
    e = sb.pop_front();
    n_vec++;
    if (!done || got !== e || e.res !== 8'h7F || e.flg[5] !== 1'b1) begin
      n_err++; $display("FAIL sub: done=%b got %h want %h", done, got, e);
    end
    issue(4'h6, 8'h05, 8'h05);
    e = sb.pop_front();
    n_vec++;
    if (!done || got !== e || result !== 8'h7F || flags[1:0] !== 2'b01 || flags[5] !== 1'b1) begin
      n_err++; $display("FAIL cmp: done=%b got %h want %h", done, got, e);
    end
  endtask

  task automatic test_mul;
    int busy_cyc = 0, k = 0;
    issue(4'hA, 8'hFF, 8'hFF);
    while (!done && k < 20) begin
      if (busy) busy_cyc++;
      if (k == 2) begin start = 1'b1; op = 4'h0; a = 8'h11; b = 8'h22; end
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    e = sb.pop_front();
    n_vec++;
    if (!done || got !== e || k != 8 || busy_cyc != 8 || busy !== 1'b0 ||
        e.res !== 8'h01 || e.hi !== 8'hFE) begin
      n_err++; $display("FAIL mul: done=%b edges=%0d busy=%0d got %h want %h (edges/busy 8)",
                        done, k, busy_cyc, got, e);
    end
    issue(4'h4, 8'h3C, 8'h0F);
    e = sb.pop_front();
    n_vec++;
    if (!done || got !== e) begin
      n_err++; $display("FAIL start_on_done: done=%b got %h want %h", done, got, e);
    end
  endtask

  task automatic test_shift;
    issue(4'h8, 8'h81, 8'h00);
    e = sb.pop_front();
    n_vec++;
    if (!done || got !== e || e.res !== 8'h02 || e.flg[3] !== 1'b1) begin
      n_err++; $display("FAIL shl: got %h want %h", got, e);
    end
    issue(4'h9, 8'h01, 8'h00);
    e = sb.pop_front();
    n_vec++;
    if (!done || got !== e || e.flg[3:2] !== 2'b11) begin
      n_err++; $display("FAIL shr: got %h want %h", got, e);
    end
  endtask

  task automatic test_illegal;
    issue(4'hD, 8'h12, 8'h34);
    e = sb.pop_front();
    n_vec++;
    if (!done || got !== e || illegal !== 1'b1) begin
      n_err++; $display("FAIL illegal: done=%b got %h want %h", done, got, e);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || illegal !== 1'b0) begin
      n_err++; $display("FAIL illegal_pulse: done=%b illegal=%b want 0 0", done, illegal);
    end
  endtask

  task automatic test_reset_mid_mul;
    int seen = 0;
    issue(4'hA, 8'h0F, 8'h0F);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    m_res = '0; m_hi = '0; m_flg = '0;
    #1;
    n_vec++;
    if ({result, result_hi, flags, busy, done, illegal} !== 27'd0) begin
      n_err++; $display("FAIL reset_mid_mul: got %h want 0", {result, result_hi, flags, busy, done, illegal});
    end
    repeat (12) begin @(posedge clk); #1; if (done) seen++; end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL abort_no_done: done cycles %0d want 0", seen); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'h0, 8'h22, 8'h33);
    e = sb.pop_front();
    n_vec++;
    if (!done || got !== e) begin
      n_err++; $display("FAIL post_reset_add: done=%b got %h want %h", done, got, e);
    end
  endtask

  task automatic test_random;
    int k;
    logic [3:0] o;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      issue(o, 8'($urandom), 8'($urandom));
      k = 0;
      while (!done && k < 20) begin @(posedge clk); #1; k++; end
      n_vec++;
      if (!done || sb.size() == 0) begin
        n_err++; $display("FAIL random_timeout: op=%h done=%b want 1", o, done);
        sb.delete();
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_err++; $display("FAIL random_op%0d: op=%h got %h want %h", i, o, got, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_adc();
    test_sub_cmp();
    test_mul();
    test_shift();
    test_illegal();
    test_reset_mid_mul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Adds a persistent flags register, carry-chained add (ADC), single-bit shifts and an iterative shift-add multiplier, behind a start/done handshake.
- Sits between the register file and the CPU control FSM. The control FSM issues one op per start pulse and waits on done.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), width of the multiply step counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  4  operation code, latched on accept
- a  in  WIDTH  operand A, latched on accept
- b  in  WIDTH  operand B, latched on accept
- result  out  WIDTH  registered result; for MUL, the low half of the product
- result_hi  out  WIDTH  high half of the MUL product; zero after any other result-writing op
- flags  out  8  registered flags: [0]EQ [1]GRT [2]Z [3]C [4]N [5]V [7:6]=0
- busy  out  1  high while a MUL is in progress
- done  out  1  one-cycle pulse when an op completes
- illegal  out  1  one-cycle pulse, coincident with done, for undefined op codes

Behaviour:
- Reset (async, rst_n=0): result=0, result_hi=0, flags=0, busy=0, done=0, illegal=0, FSM→IDLE, counter=0. Reset during a MUL aborts it with no done.
- Accept: rising edge with start=1 and busy=0. While busy=1, start is ignored; there is no queuing.
- Op codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT(A), 0110 CMP, 0111 ADC (A+B+flags.C), 1000 SHL (A<<1), 1001 SHR (logical A>>1), 1010 MUL (unsigned).
- Undefined codes 1011–1111: result and flags unchanged; done=1 and illegal=1 on the next cycle.
- Single-cycle ops (all except MUL):
  - Result and flags are written on the accept edge; done=1 for the following cycle; busy stays 0.
  - Back-to-back starts on consecutive cycles are legal, and ADC sees the C written by the previous op.
- Flag rules for ADD/SUB/ADC/AND/OR/XOR/NOT/SHL/SHR:
  - Z = (result==0); N = result[WIDTH-1]; EQ and GRT are held.
  - ADD/ADC: C = carry out; V = signed overflow.
  - SUB: C = borrow (A<B unsigned); V = signed overflow of A−B.
  - AND/OR/XOR/NOT: C=0, V=0.
  - SHL: C = A[WIDTH-1], V=0.
  - SHR: C = A[0], V=0.
- CMP: result and result_hi unchanged; EQ=(A==B), GRT=(A>B unsigned); Z/C/N/V held.
- MUL FSM: IDLE→MUL on accept.
  - Accept edge: latch A and B, clear the accumulator, counter=WIDTH, busy=1.
  - Each MUL cycle performs one shift-add step and decrements the counter.
  - On the edge where the counter reaches 0: {result_hi,result}=A×B (2·WIDTH bits, no truncation); Z=(product==0); C=(result_hi!=0); N=0, V=0; EQ and GRT held; busy=0; done=1 next cycle; FSM→IDLE.
  - Latency from accept edge to result edge is WIDTH+1 edges.
  - a, b and op changes during busy have no effect.
  - A new start is accepted on the cycle done is high, because busy is already 0.
- done and illegal are never high for more than one consecutive cycle per accepted op.
- All arithmetic is modulo 2^WIDTH except the MUL product.

Test Plan:
- Reset with rst_n=0 mid-MUL (WIDTH=8, A=0x0F, B=0x0F, 3 cycles in) → all outputs 0 immediately, no done; after release, IDLE accepts a new op.
- ADD A=0xFF B=0x01, then ADC A=0x00 B=0x00 on the next cycle → result 0x00 with Z=1 C=1 V=0; then result 0x01 with C=0 Z=0; done pulses on each of two consecutive cycles.
- SUB A=0x80 B=0x01 → result 0x7F, V=1, N=0, C=0. Then CMP A=0x05 B=0x05 → EQ=1, GRT=0, result still 0x7F, V still 1.
- MUL A=0xFF B=0xFF → busy high 8 cycles, then result=0x01, result_hi=0xFE, C=1, done after 9 edges. A start asserted while busy is ignored; a start on the done cycle is accepted.
- SHL A=0x81 → result 0x02, C=1; SHR A=0x01 → result 0x00, Z=1, C=1.
- op=1101 → done=1 and illegal=1 for exactly one cycle; result and flags unchanged.
